// File: rtl/param_regbank.sv
// Parameterised control/status register bank. Each register has its own
// access mode, and a key-sequence lock can write-protect selected
// registers. Reads are registered: data appears one cycle after the strobe.
module param_regbank #(
  parameter int unsigned               DATA_W       = 32,
  parameter int unsigned               NUM_REGS     = 8,
  parameter int unsigned               ADDR_W       = 8,
  parameter logic [3*NUM_REGS-1:0]      MODES        = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VALS     = '0,
  parameter logic [NUM_REGS-1:0]        LOCK_MASK    = '0,
  parameter logic [DATA_W-1:0]          KEY1         = 'h5A,
  parameter logic [DATA_W-1:0]          KEY2         = 'hA5,
  parameter int unsigned               LOCK_TIMEOUT = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            addr,
  input  logic                         chip_select,
  input  logic                         write_en,
  input  logic                         read_en,
  input  logic [DATA_W-1:0]            write_data,
  output logic [DATA_W-1:0]            read_data,
  output logic                         data_valid,
  output logic                         rd_err,
  input  logic [NUM_REGS-1:0]          hw_wen,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_wdata,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic                         locked,
  output logic                         irq
);

  typedef enum logic [2:0] {
    M_RW = 3'd0, M_RO = 3'd1, M_W1C = 3'd2, M_W1S = 3'd3,
    M_WO = 3'd4, M_RC = 3'd5, M_PULSE = 3'd6, M_RO7 = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    S_LOCKED = 2'd0, S_ARMED = 2'd1, S_UNLOCKED = 2'd2
  } lock_e;

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] LOCK_IDX = IDX_W'(NUM_REGS);

  lock_e              r_state;
  logic [CNT_W-1:0]   r_idle;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_valid;
  logic               r_rd_err;
  logic               r_irq;

  logic [IDX_W-1:0]    w_idx;
  logic                w_write;
  logic                w_read;
  logic                w_is_reg;
  logic                w_is_lock;
  logic                w_locked;
  logic [NUM_REGS-1:0] w_irq_bits;
  logic [DATA_W-1:0]   w_rd_val;
  logic                w_unused;

  assign w_idx     = addr[ADDR_W-1:2];
  assign w_write   = chip_select & write_en;
  assign w_read    = chip_select & read_en;
  assign w_is_lock = (w_idx == LOCK_IDX);
  assign w_is_reg  = (w_idx < LOCK_IDX);
  assign w_locked  = (r_state != S_UNLOCKED);
  // Byte-lane bits and per-mode unused hardware inputs are intentionally ignored.
  assign w_unused  = ^{addr[1:0], hw_wen, hw_wdata, hw_set};

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam mode_e MODE = mode_e'(MODES[3*gi +: 3]);
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] w_nxt;
    logic              w_wr;
    logic              w_rd;

    assign w_wr = w_write & w_is_reg & (w_idx == IDX_W'(gi)) & ~(LOCK_MASK[gi] & w_locked);
    assign w_rd = w_read & w_is_reg & (w_idx == IDX_W'(gi));

    // Next value by access mode; software write beats hw_wen, hw_set is OR-ed last.
    always_comb begin
      w_nxt = r_q;
      case (MODE)
        M_RW: begin
          if (w_wr)              w_nxt = write_data;
          else if (hw_wen[gi])   w_nxt = hw_wdata[gi*DATA_W +: DATA_W];
        end
        M_W1C: begin
          if (w_wr) w_nxt = r_q & ~write_data;
          w_nxt = w_nxt | hw_set[gi*DATA_W +: DATA_W];
        end
        M_W1S: begin
          if (w_wr) w_nxt = r_q | write_data;
        end
        M_WO: begin
          if (w_wr) w_nxt = write_data;
        end
        M_RC: begin
          if (w_wr)      w_nxt = write_data;
          else if (w_rd) w_nxt = '0;
          w_nxt = w_nxt | hw_set[gi*DATA_W +: DATA_W];
        end
        M_PULSE: begin
          w_nxt = w_wr ? write_data : '0;
        end
        default: begin
          if (hw_wen[gi]) w_nxt = hw_wdata[gi*DATA_W +: DATA_W];
        end
      endcase
    end

    // Register storage with per-register reset value.
    always_ff @(posedge clk) begin
      if (rst) r_q <= RST_VALS[gi*DATA_W +: DATA_W];
      else     r_q <= w_nxt;
    end

    assign reg_q[gi*DATA_W +: DATA_W] = r_q;
    // irq follows the value being loaded so it lines up with reg_q.
    assign w_irq_bits[gi] = (MODE == M_W1C) ? |w_nxt : 1'b0;
  end

  // Read mux over current (pre-write) contents; WO reads zero.
  always_comb begin
    w_rd_val = '0;
    if (w_is_lock) begin
      w_rd_val[1:0] = r_state;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (w_is_reg && (w_idx == IDX_W'(i)) && (mode_e'(MODES[3*i +: 3]) != M_WO))
          w_rd_val = reg_q[i*DATA_W +: DATA_W];
      end
    end
  end

  // Registered read port; read_data holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_valid  <= 1'b0;
      r_rd_err <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_valid  <= w_read;
      r_rd_err <= w_read & ~w_is_reg & ~w_is_lock;
      r_irq    <= |w_irq_bits;
      if (w_read) r_rdata <= w_rd_val;
    end
  end

  // Lock FSM with idle auto-relock while unlocked.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOCKED;
      r_idle  <= '0;
    end else begin
      case (r_state)
        S_LOCKED: begin
          r_idle <= '0;
          if (w_write && w_is_lock && (write_data == KEY1)) r_state <= S_ARMED;
        end
        S_ARMED: begin
          r_idle <= '0;
          if (w_write) begin
            if (w_is_lock && (write_data == KEY2)) r_state <= S_UNLOCKED;
            else                                   r_state <= S_LOCKED;
          end
        end
        S_UNLOCKED: begin
          if (w_write) begin
            r_idle <= '0;
            if (w_is_lock) r_state <= S_LOCKED;
          end else if (r_idle == CNT_W'(LOCK_TIMEOUT - 1)) begin
            r_idle  <= '0;
            r_state <= S_LOCKED;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end
        default: begin
          r_idle  <= '0;
          r_state <= S_LOCKED;
        end
      endcase
    end
  end

  assign read_data  = r_rdata;
  assign data_valid = r_valid;
  assign rd_err     = r_rd_err;
  assign locked     = w_locked;
  assign irq        = r_irq;

endmodule

// File: tb/tb_param_regbank.sv
// Directed bench for param_regbank: reg0 RW (lock-protected), reg1 W1C,
// reg2 RC, reg3 PULSE, reg4 WO, reg5 W1S, reg6 RO, reg7 RW.
module tb_param_regbank;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 8;
  localparam int unsigned AW = 8;
  localparam logic [3*NR-1:0] TB_MODES =
    {3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd5, 3'd2, 3'd0};
  localparam logic [NR*DW-1:0] TB_RST =
    {32'h0000_1234, 32'hDEAD_BEEF, {6{32'h0}}};

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } rd_exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    addr;
  logic             chip_select, write_en, read_en;
  logic [DW-1:0]    write_data;
  logic [DW-1:0]    read_data;
  logic             data_valid, rd_err;
  logic [NR-1:0]    hw_wen;
  logic [NR*DW-1:0] hw_wdata, hw_set, reg_q;
  logic             locked, irq;

  int unsigned total = 0;
  int unsigned bad   = 0;
  rd_exp_t     sb[$];

  param_regbank #(
    .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .MODES(TB_MODES),
    .RST_VALS(TB_RST), .LOCK_MASK(8'h01), .KEY1(32'h5A), .KEY2(32'hA5),
    .LOCK_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .chip_select(chip_select),
    .write_en(write_en), .read_en(read_en), .write_data(write_data),
    .read_data(read_data), .data_valid(data_valid), .rd_err(rd_err),
    .hw_wen(hw_wen), .hw_wdata(hw_wdata), .hw_set(hw_set), .reg_q(reg_q),
    .locked(locked), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] q(input int unsigned i);
    return reg_q[i*DW +: DW];
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    chip_select = 0; write_en = 0; read_en = 0;
    hw_wen = '0; hw_set = '0;
  endtask

  task automatic bus_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    chip_select = 1; write_en = 1; read_en = 0; addr = a; write_data = d;
    step();
    idle();
  endtask

  // Issue a read, queue its expectation, and compare what comes back next cycle.
  task automatic bus_rd(input string tag, input logic [AW-1:0] a,
                        input logic [DW-1:0] exp_d, input logic exp_e);
    rd_exp_t e;
    chip_select = 1; read_en = 1; write_en = 0; addr = a;
    sb.push_back('{data: exp_d, err: exp_e});
    step();
    idle();
    check({tag, ".valid"}, DW'(data_valid), 32'd1);
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".data"}, read_data, e.data);
      check({tag, ".err"}, DW'(rd_err), DW'(e.err));
    end
  endtask

  initial begin
    rst = 1; addr = '0; write_data = '0; hw_wdata = '0;
    idle();
    step(); step();
    check("rst.valid_in_rst", DW'(data_valid), 32'd0);
    rst = 0;
    step();
    check("rst.locked", DW'(locked), 32'd1);
    check("rst.rdata", read_data, 32'd0);
    check("rst.rd_err", DW'(rd_err), 32'd0);
    check("rst.irq", DW'(irq), 32'd0);
    check("rst.reg0", q(0), 32'd0);
    check("rst.reg6", q(6), 32'hDEAD_BEEF);
    check("rst.reg7", q(7), 32'h0000_1234);

    // Lock protection and unlock sequence on reg0.
    bus_wr(8'd0, 32'h12);
    bus_rd("lock.reg0_locked", 8'd0, 32'h0, 1'b0);
    bus_rd("lock.state0", 8'd32, 32'd0, 1'b0);
    bus_wr(8'd32, 32'h5A);
    bus_rd("lock.armed", 8'd32, 32'd1, 1'b0);
    bus_wr(8'd32, 32'hA5);
    bus_rd("lock.unlocked", 8'd32, 32'd2, 1'b0);
    check("lock.locked_low", DW'(locked), 32'd0);
    bus_wr(8'd0, 32'h12);
    bus_rd("lock.reg0_open", 8'd0, 32'h12, 1'b0);
    bus_wr(8'd32, 32'h0);
    check("lock.relock_write", DW'(locked), 32'd1);

    // W1C with hw_set and irq.
    hw_set[1*DW +: DW] = 32'h0F;
    step();
    idle();
    step();
    check("w1c.irq_set", DW'(irq), 32'd1);
    check("w1c.q", q(1), 32'h0F);
    bus_wr(8'd4, 32'h03);
    bus_rd("w1c.clear", 8'd4, 32'h0C, 1'b0);
    hw_set[1*DW +: DW] = 32'h04;
    bus_wr(8'd4, 32'h0C);
    bus_rd("w1c.set_wins", 8'd4, 32'h04, 1'b0);
    bus_wr(8'd4, 32'h04);
    step();
    check("w1c.irq_clear", DW'(irq), 32'd0);

    // Read-clear.
    hw_set[2*DW +: DW] = 32'h80;
    step();
    idle();
    bus_rd("rc.first", 8'd8, 32'h80, 1'b0);
    bus_rd("rc.second", 8'd8, 32'h0, 1'b0);

    // Pulse register.
    bus_wr(8'd12, 32'h1);
    check("pulse.high", q(3), 32'h1);
    step();
    check("pulse.low", q(3), 32'h0);

    // Write-only and write-1-set.
    bus_wr(8'd16, 32'hAB);
    check("wo.q", q(4), 32'hAB);
    bus_rd("wo.read0", 8'd16, 32'h0, 1'b0);
    bus_wr(8'd20, 32'h3);
    bus_wr(8'd20, 32'h8);
    bus_rd("w1s.accum", 8'd20, 32'hB, 1'b0);

    // Read-only: software ignored, hardware loads.
    bus_wr(8'd24, 32'h0);
    bus_rd("ro.sw_ignored", 8'd24, 32'hDEAD_BEEF, 1'b0);
    hw_wen[6] = 1; hw_wdata[6*DW +: DW] = 32'h55;
    step();
    idle();
    bus_rd("ro.hw_load", 8'd24, 32'h55, 1'b0);

    // Same-cycle read+write returns pre-write value; sw write beats hw_wen.
    chip_select = 1; write_en = 1; read_en = 1; addr = 8'd28; write_data = 32'h99;
    hw_wen[7] = 1; hw_wdata[7*DW +: DW] = 32'h77;
    sb.push_back('{data: 32'h1234, err: 1'b0});
    step();
    idle();
    check("rw.same_valid", DW'(data_valid), 32'd1);
    begin
      rd_exp_t e;
      e = sb.pop_front();
      check("rw.same_pre", read_data, e.data);
    end
    check("rw.sw_wins", q(7), 32'h99);
    bus_rd("rw.after", 8'd28, 32'h99, 1'b0);

    // Idle timeout relock, then ARMED aborted by write elsewhere.
    bus_wr(8'd32, 32'h5A);
    bus_wr(8'd32, 32'hA5);
    step(); step(); step();
    check("timeout.still_open", DW'(locked), 32'd0);
    step();
    check("timeout.relocked", DW'(locked), 32'd1);
    bus_wr(8'd32, 32'h5A);
    bus_rd("abort.armed", 8'd32, 32'd1, 1'b0);
    bus_wr(8'd0, 32'h77);
    bus_rd("abort.state", 8'd32, 32'd0, 1'b0);
    bus_rd("abort.reg0_kept", 8'd0, 32'h12, 1'b0);
    bus_wr(8'd32, 32'h5A);
    bus_wr(8'd32, 32'h33);
    bus_rd("abort.badkey", 8'd32, 32'd0, 1'b0);

    // Out-of-range read.
    bus_rd("oor.36", 8'd36, 32'h0, 1'b1);
    bus_rd("oor.252", 8'd252, 32'h0, 1'b1);

    // Reset mid-sequence and mid-read discards both.
    bus_wr(8'd32, 32'h5A);
    rst = 1; chip_select = 1; read_en = 1; addr = 8'd32;
    step();
    rst = 0;
    idle();
    check("rst_mid.no_valid", DW'(data_valid), 32'd0);
    check("rst_mid.rdata", read_data, 32'd0);
    bus_rd("rst_mid.state", 8'd32, 32'd0, 1'b0);
    check("rst_mid.reg7", q(7), 32'h0000_1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
